// File: rtl/extreme_val_update_module_pkg.sv
// Shared types and layout constants for the flow extreme-value cache update path.
package extreme_val_update_module_pkg;

  localparam int DEF_ADDR_W     = 12;
  localparam int DEF_FEAT_W     = 8;
  localparam int DEF_VEC_W      = 160;
  localparam int DEF_RD_TIMEOUT = 4;
  localparam int ENTRY_W        = DEF_VEC_W + 4 * DEF_FEAT_W;

  // Bit offsets of each field inside the 192-bit cache entry
  localparam int VEC_LSB      = 32;
  localparam int MAX_SIZE_LSB = 24;
  localparam int MIN_SIZE_LSB = 16;
  localparam int MAX_ARIT_LSB = 8;
  localparam int MIN_ARIT_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_MERGE,
    ST_WRITE
  } state_e;

endpackage

// File: rtl/extreme_val_update_module_if.sv
// Packet-record, cache-read and cache-write signals of the extreme-value updater.
interface extreme_val_update_module_if
  import extreme_val_update_module_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int FEAT_W = DEF_FEAT_W,
  parameter int VEC_W  = DEF_VEC_W
);
  logic                      pkt_v;
  logic                      pkt_rdy;
  logic [ADDR_W-1:0]         pkt_addr;
  logic                      pkt_new_flow;
  logic [FEAT_W-1:0]         pkt_size;
  logic [FEAT_W-1:0]         pkt_arit;
  logic                      rd_mem;
  logic [ADDR_W-1:0]         rd_addr;
  logic                      rd_data_v;
  logic [FEAT_W-1:0]         i_max_pkt_size;
  logic [FEAT_W-1:0]         i_min_pkt_size;
  logic [FEAT_W-1:0]         i_max_pkt_arit;
  logic [FEAT_W-1:0]         i_min_pkt_arit;
  logic [VEC_W-1:0]          i_vec_feature;
  logic [ADDR_W-1:0]         wr_addr;
  logic [VEC_W+4*FEAT_W-1:0] wr_data;
  logic                      wea;
  logic                      o_rd_err;
  logic [31:0]               o_upd_cnt;

  modport slave (
    input  pkt_v, pkt_addr, pkt_new_flow, pkt_size, pkt_arit, rd_data_v,
           i_max_pkt_size, i_min_pkt_size, i_max_pkt_arit, i_min_pkt_arit, i_vec_feature,
    output pkt_rdy, rd_mem, rd_addr, wr_addr, wr_data, wea, o_rd_err, o_upd_cnt
  );

  modport master (
    output pkt_v, pkt_addr, pkt_new_flow, pkt_size, pkt_arit, rd_data_v,
           i_max_pkt_size, i_min_pkt_size, i_max_pkt_arit, i_min_pkt_arit, i_vec_feature,
    input  pkt_rdy, rd_mem, rd_addr, wr_addr, wr_data, wea, o_rd_err, o_upd_cnt
  );
endinterface

// File: rtl/extreme_val_update_module_merge.sv
// Combinational merge of a stored cache entry with one packet record:
// unsigned max/min of size and inter-arrival, byte-shift of the size history.
module extreme_val_merge
  import extreme_val_update_module_pkg::*;
#(
  parameter int FEAT_W = DEF_FEAT_W,
  parameter int VEC_W  = DEF_VEC_W
) (
  input  logic                      new_flow_i,
  input  logic [FEAT_W-1:0]         pkt_size_i,
  input  logic [FEAT_W-1:0]         pkt_arit_i,
  input  logic [FEAT_W-1:0]         base_max_size_i,
  input  logic [FEAT_W-1:0]         base_min_size_i,
  input  logic [FEAT_W-1:0]         base_max_arit_i,
  input  logic [FEAT_W-1:0]         base_min_arit_i,
  input  logic [VEC_W-1:0]          base_vec_i,
  output logic [VEC_W+4*FEAT_W-1:0] entry_o
);

  function automatic logic [FEAT_W-1:0] fmax(input logic [FEAT_W-1:0] a, input logic [FEAT_W-1:0] b);
    return (b > a) ? b : a;
  endfunction

  function automatic logic [FEAT_W-1:0] fmin(input logic [FEAT_W-1:0] a, input logic [FEAT_W-1:0] b);
    return (b < a) ? b : a;
  endfunction

  always_comb begin
    entry_o = '0;
    if (new_flow_i) begin
      entry_o = {{(VEC_W-FEAT_W){1'b0}}, pkt_size_i,
                 pkt_size_i, pkt_size_i, pkt_arit_i, pkt_arit_i};
    end else begin
      // Oldest history byte falls off the top, newest size enters the LSBs
      entry_o = {base_vec_i[VEC_W-FEAT_W-1:0], pkt_size_i,
                 fmax(base_max_size_i, pkt_size_i), fmin(base_min_size_i, pkt_size_i),
                 fmax(base_max_arit_i, pkt_arit_i), fmin(base_min_arit_i, pkt_arit_i)};
    end
  end

endmodule

// File: rtl/extreme_val_update_module.sv
// Read-modify-write updater for one flow's extreme-value cache entry per packet record.
// Optional completed-write counter enabled by defining EXTREME_VAL_UPD_CNT_EN.
module extreme_val_update_module
  import extreme_val_update_module_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FEAT_W     = DEF_FEAT_W,
  parameter int VEC_W      = DEF_VEC_W,
  parameter int RD_TIMEOUT = DEF_RD_TIMEOUT
) (
  input logic                         clk,
  input logic                         rst,
  extreme_val_update_module_if.slave  bus
);

  localparam int ENT_W = VEC_W + 4 * FEAT_W;
  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               rdy_en_q;
  logic               load_pkt_d, load_base_d;
  logic [ADDR_W-1:0]  addr_q;
  logic               new_flow_q;
  logic [FEAT_W-1:0]  size_q, arit_q;
  logic [FEAT_W-1:0]  bmax_size_q, bmin_size_q, bmax_arit_q, bmin_arit_q;
  logic [VEC_W-1:0]   bvec_q;
  logic [ENT_W-1:0]   merged;
  logic [ENT_W-1:0]   wr_data_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = 1'b0;
    load_pkt_d  = 1'b0;
    load_base_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.pkt_v && rdy_en_q) begin
          load_pkt_d = 1'b1;
          state_d    = bus.pkt_new_flow ? ST_MERGE : ST_READ;
        end
      end
      ST_READ: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.rd_data_v) begin
          load_base_d = 1'b1;
          state_d     = ST_MERGE;
        end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_MERGE: state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Control and externally visible registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      rdy_en_q   <= 1'b0;
      addr_q     <= '0;
      new_flow_q <= 1'b0;
      wr_data_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rdy_en_q <= 1'b1;
      if (load_pkt_d) begin
        addr_q     <= bus.pkt_addr;
        new_flow_q <= bus.pkt_new_flow;
      end
      if (state_q == ST_MERGE) wr_data_q <= merged;
    end
  end

  // Datapath holding registers; only read after being loaded
  always_ff @(posedge clk) begin
    if (load_pkt_d) begin
      size_q <= bus.pkt_size;
      arit_q <= bus.pkt_arit;
    end
    if (load_base_d) begin
      bmax_size_q <= bus.i_max_pkt_size;
      bmin_size_q <= bus.i_min_pkt_size;
      bmax_arit_q <= bus.i_max_pkt_arit;
      bmin_arit_q <= bus.i_min_pkt_arit;
      bvec_q      <= bus.i_vec_feature;
    end
  end

  extreme_val_merge #(.FEAT_W(FEAT_W), .VEC_W(VEC_W)) u_merge (
    .new_flow_i      (new_flow_q),
    .pkt_size_i      (size_q),
    .pkt_arit_i      (arit_q),
    .base_max_size_i (bmax_size_q),
    .base_min_size_i (bmin_size_q),
    .base_max_arit_i (bmax_arit_q),
    .base_min_arit_i (bmin_arit_q),
    .base_vec_i      (bvec_q),
    .entry_o         (merged)
  );

  assign bus.pkt_rdy  = rdy_en_q && (state_q == ST_IDLE);
  assign bus.rd_mem   = (state_q == ST_READ);
  assign bus.rd_addr  = addr_q;
  assign bus.wr_addr  = addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.wea      = (state_q == ST_WRITE);
  assign bus.o_rd_err = err_q;

`ifdef EXTREME_VAL_UPD_CNT_EN
  logic [31:0] upd_cnt_q, upd_cnt_d;

  assign upd_cnt_d = (state_q == ST_WRITE) ? upd_cnt_q + 32'd1 : upd_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) upd_cnt_q <= '0;
    else     upd_cnt_q <= upd_cnt_d;
  end

  assign bus.o_upd_cnt = upd_cnt_q;
`else
  assign bus.o_upd_cnt = '0;
`endif

endmodule

// File: tb/tb_extreme_val_update_module.sv
// Bench for extreme_val_update_module: vector table through a write scoreboard,
// plus timeout, stray read-valid, mid-operation reset and update-counter sequences.
module tb_extreme_val_update_module;

  typedef struct {
    logic         nf;
    logic [11:0]  addr;
    logic [7:0]   size, arit, mxs, mns, mxa, mna;
    logic [159:0] svec;
    logic [31:0]  lo;
    logic [159:0] ev;
  } vec_t;

  typedef struct {
    logic [11:0]  addr;
    logic [191:0] data;
    int           cyc;
    int           lat;
  } sb_t;

`ifdef EXTREME_VAL_UPD_CNT_EN
  localparam int EXP_UPD = 3;
`else
  localparam int EXP_UPD = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic resp_en, stray, rdm_d1, rdm_d2;
  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;
  int   wea_cnt = 0, rdm_cnt = 0;
  sb_t  sb[$];
  sb_t  mon_e;
  vec_t tbl[7];

  always #5 clk = ~clk;

  extreme_val_update_module_if #(.ADDR_W(12), .FEAT_W(8), .VEC_W(160)) bus ();

  extreme_val_update_module #(.ADDR_W(12), .FEAT_W(8), .VEC_W(160), .RD_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Cache model: read data valid two cycles after the read strobe
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rdm_d1 <= 1'b0;
      rdm_d2 <= 1'b0;
    end else begin
      rdm_d1 <= bus.rd_mem;
      rdm_d2 <= rdm_d1;
    end
  end
  assign bus.rd_data_v = (rdm_d2 & resp_en) | stray;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rd_mem) rdm_cnt++;
      if (bus.wea) begin
        wea_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_wea", bus.wea, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("wr_addr", bus.wr_addr, mon_e.addr);
          chk("wr_data", bus.wr_data, mon_e.data);
          chk("wea_latency", cyc - mon_e.cyc, mon_e.lat);
        end
      end
    end
  end

  function automatic vec_t mk(logic nf, logic [11:0] a, logic [7:0] s, logic [7:0] ar,
                              logic [7:0] mxs, logic [7:0] mns, logic [7:0] mxa, logic [7:0] mna,
                              logic [159:0] sv, logic [31:0] lo, logic [159:0] ev);
    vec_t v;
    v.nf = nf; v.addr = a; v.size = s; v.arit = ar;
    v.mxs = mxs; v.mns = mns; v.mxa = mxa; v.mna = mna;
    v.svec = sv; v.lo = lo; v.ev = ev;
    return v;
  endfunction

  task automatic send(input vec_t v, input bit expect_wr, output int dc);
    int n = 0;
    while (!bus.pkt_rdy && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!bus.pkt_rdy) chk("pkt_rdy_wait", bus.pkt_rdy, 1);
    bus.i_max_pkt_size = v.mxs;
    bus.i_min_pkt_size = v.mns;
    bus.i_max_pkt_arit = v.mxa;
    bus.i_min_pkt_arit = v.mna;
    bus.i_vec_feature  = v.svec;
    bus.pkt_addr       = v.addr;
    bus.pkt_new_flow   = v.nf;
    bus.pkt_size       = v.size;
    bus.pkt_arit       = v.arit;
    bus.pkt_v          = 1'b1;
    dc = cyc;
    if (expect_wr) sb.push_back('{addr: v.addr, data: {v.ev, v.lo}, cyc: cyc, lat: (v.nf ? 2 : 5)});
    @(negedge clk);
    bus.pkt_v = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic timeout_seq(input vec_t v);
    int dc, n, w0;
    n = 0;
    w0 = wea_cnt;
    resp_en = 1'b0;
    send(v, 1'b0, dc);
    while (!bus.o_rd_err && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rd_err_seen", bus.o_rd_err, 1);
    chk("rd_err_latency", cyc - dc, 6);
    chk("rdy_at_rd_err", bus.pkt_rdy, 1);
    @(negedge clk);
    chk("rd_err_one_cycle", bus.o_rd_err, 0);
    resp_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_wea_on_timeout", wea_cnt - w0, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dc, w0, r0, nrd;
    rst = 1'b1;
    resp_en = 1'b1;
    stray = 1'b0;
    bus.pkt_v = 1'b0;
    bus.pkt_addr = '0;
    bus.pkt_new_flow = 1'b0;
    bus.pkt_size = '0;
    bus.pkt_arit = '0;
    bus.i_max_pkt_size = '0;
    bus.i_min_pkt_size = '0;
    bus.i_max_pkt_arit = '0;
    bus.i_min_pkt_arit = '0;
    bus.i_vec_feature = '0;

    tbl[0] = mk(1, 12'h005, 8'h40, 8'h10, 8'hFF, 8'hFF, 8'hFF, 8'hFF, {160{1'b1}},
                32'h40401010, 160'h40);
    tbl[1] = mk(0, 12'h123, 8'h90, 8'h02, 8'h80, 8'h20, 8'h30, 8'h05,
                160'hAB000000_00000000_00000000_00000000_00000011,
                32'h90203002, 160'h00000000_00000000_00000000_00000000_00001190);
    tbl[2] = mk(0, 12'hFFF, 8'h50, 8'h30, 8'h80, 8'h20, 8'h30, 8'h05,
                160'h01020304_05060708_090A0B0C_0D0E0F10_11121314,
                32'h80203005, 160'h02030405_06070809_0A0B0C0D_0E0F1011_12131450);
    tbl[3] = mk(0, 12'h000, 8'h10, 8'hFF, 8'h80, 8'h20, 8'h30, 8'h05, 160'h0,
                32'h8010FF05, 160'h10);
    tbl[4] = mk(0, 12'h7A5, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, {160{1'b1}},
                32'hFF00FF00, {{152{1'b1}}, 8'h00});
    tbl[5] = mk(1, 12'hABC, 8'hFF, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 160'h5,
                32'hFFFF0000, 160'hFF);
    tbl[6] = mk(0, 12'hABC, 8'h80, 8'h06, 8'h7F, 8'h20, 8'h30, 8'h05, 160'h7,
                32'h80203005, 160'h780);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_pkt_rdy", bus.pkt_rdy, 0);
    chk("rst_rd_mem", bus.rd_mem, 0);
    chk("rst_wea", bus.wea, 0);
    chk("rst_rd_err", bus.o_rd_err, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_upd_cnt", bus.o_upd_cnt, 0);
    rst = 1'b0;
    #1;
    chk("rdy_release_cycle", bus.pkt_rdy, 0);
    @(negedge clk);
    chk("rdy_after_release", bus.pkt_rdy, 1);

    // Vector table, issued back to back
    r0 = rdm_cnt;
    w0 = wea_cnt;
    nrd = 0;
    for (int i = 0; i < 7; i++) begin
      send(tbl[i], 1'b1, dc);
      if (!tbl[i].nf) nrd++;
    end
    drain();
    chk("rd_mem_pulses", rdm_cnt - r0, nrd);
    chk("wea_pulses", wea_cnt - w0, 7);

    // rd_data_v while idle must not start anything
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    chk("stray_rdy", bus.pkt_rdy, 1);
    repeat (4) @(negedge clk);
    chk("stray_no_wea", wea_cnt - w0, 7);
    chk("stray_no_rd_mem", rdm_cnt - r0, nrd);

    timeout_seq(tbl[1]);

    // Reset while waiting for read data
    resp_en = 1'b0;
    w0 = wea_cnt;
    send(tbl[2], 1'b0, dc);
    @(negedge clk);
    chk("wait_rd_addr", bus.rd_addr, 12'hFFF);
    rst = 1'b1;
    #1;
    chk("mid_rst_pkt_rdy", bus.pkt_rdy, 0);
    chk("mid_rst_rd_mem", bus.rd_mem, 0);
    chk("mid_rst_wea", bus.wea, 0);
    chk("mid_rst_rd_addr", bus.rd_addr, 0);
    chk("mid_rst_wr_addr", bus.wr_addr, 0);
    chk("mid_rst_wr_data", bus.wr_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    resp_en = 1'b1;
    #1;
    chk("mid_rst_rdy_release", bus.pkt_rdy, 0);
    @(negedge clk);
    chk("mid_rst_rdy_after", bus.pkt_rdy, 1);
    repeat (8) @(negedge clk);
    chk("mid_rst_no_wea", wea_cnt - w0, 0);

    // Three completed updates and one timeout since the last reset
    send(tbl[0], 1'b1, dc);
    send(tbl[1], 1'b1, dc);
    send(tbl[3], 1'b1, dc);
    drain();
    timeout_seq(tbl[2]);
    chk("upd_cnt", bus.o_upd_cnt, EXP_UPD);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/extreme_val_update_module.md
Name: extreme_val_update_module

Overview:
- Write-side companion of the flow extreme-value cache. It accepts one per-packet record (flow address, packet size, inter-arrival time) and performs a read-modify-write on that flow's 192-bit cache entry.
- It updates max/min packet size, max/min inter-arrival and the 20-byte packet-size history vector, then writes the entry back.
- Sits between the TFE packet parser and the cache's rd_mem/rd_addr and wr_addr/wr_data/wea ports.

Parameters:
ADDR_W, 12, flow cache address width
FEAT_W, 8, width of each scalar feature
VEC_W, 160, history vector width (VEC_W/FEAT_W entries)
RD_TIMEOUT, 4, cycles allowed in WAIT for rd_data_v before abort

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
pkt_v  in  1  packet record valid
pkt_rdy  out  1  block can accept a record; transfer occurs when pkt_v & pkt_rdy
pkt_addr  in  ADDR_W  flow cache address
pkt_new_flow  in  1  first packet of flow; ignore stored entry
pkt_size  in  FEAT_W  packet size feature
pkt_arit  in  FEAT_W  inter-arrival feature
rd_mem  out  1  one-cycle read strobe to cache
rd_addr  out  ADDR_W  read address
rd_data_v  in  1  cache read data valid (2 cycles after rd_mem)
i_max_pkt_size, i_min_pkt_size, i_max_pkt_arit, i_min_pkt_arit  in  FEAT_W each  stored extremes
i_vec_feature  in  VEC_W  stored history vector
wr_addr  out  ADDR_W  write address
wr_data  out  VEC_W+4*FEAT_W  write data
wea  out  1  one-cycle write enable
o_rd_err  out  1  one-cycle pulse on read timeout
o_upd_cnt  out  32  completed write count (feature-gated)

Behaviour:
- Reset (async, active-high): state=IDLE; pkt_rdy=0 during reset, 1 the cycle after release; rd_mem=0, wea=0, o_rd_err=0; rd_addr, wr_addr, wr_data=0; o_upd_cnt=0. Reset mid-operation drops the in-flight record; no write is issued.
- FSM states: IDLE, READ, WAIT, MERGE, WRITE.
- IDLE: pkt_rdy=1. On handshake, latch addr/new_flow/size/arit. If new_flow, go to MERGE; otherwise go to READ.
- READ: rd_mem=1 for exactly one cycle, rd_addr=latched addr, then go to WAIT with the timeout counter cleared.
- WAIT: on rd_data_v, capture the i_* buses into the base register and go to MERGE. Otherwise increment the counter. When the counter reaches RD_TIMEOUT, pulse o_rd_err and return to IDLE with no write.
- MERGE: compute the new entry into the wr_data register.
  - new_flow: max/min size=pkt_size, max/min arit=pkt_arit, vec={(VEC_W-FEAT_W)'0, pkt_size}.
  - Otherwise: max_size=max(base,pkt_size); min_size=min(base,pkt_size); same rule for arit. All comparisons are unsigned. vec={base_vec[VEC_W-FEAT_W-1:0], pkt_size}: shift left one byte, oldest byte discarded, newest byte in the LSBs.
- WRITE: wea=1 for one cycle with wr_addr/wr_data, then go to IDLE.
- wr_data layout: [191:32] vec, [31:24] max size, [23:16] min size, [15:8] max arit, [7:0] min arit.
- Latency, handshake to wea: existing flow = 5 cycles (READ, WAIT x2, MERGE, WRITE); new flow = 2 cycles. Throughput is one record per 6 or 3 cycles.
- rd_data_v outside WAIT is ignored.
- Equal values leave extremes unchanged.
- A back-to-back packet to the same address is safe: its read is issued at least one cycle after the prior wea.

Optional Feature:
- Macro EXTREME_VAL_UPD_CNT_EN.
- Defined: o_upd_cnt increments on every wea cycle and wraps at 2^32.
- Undefined: the counter logic is absent and o_upd_cnt is tied to 0.
- All other behaviour is identical in both cases.

Decomposition:
- Shared package holds:
  - FSM state typedef;
  - field offsets for the 192-bit entry layout (VEC_LSB=32, MAX_SIZE_LSB=24, MIN_SIZE_LSB=16, MAX_ARIT_LSB=8, MIN_ARIT_LSB=0);
  - default widths.
- One natural sub-module: extreme_val_merge, the combinational max/min/shift unit from base + packet to the new entry, so it can be reused and unit-tested.

Test Plan:
- New flow: addr=0x005, size=0x40, arit=0x10 -> no rd_mem; wea 2 cycles after handshake, wr_data[31:0]=0x40401010, vec=0x...0040.
- Existing flow: stored max/min size=0x80/0x20, arit=0x30/0x05, vec LSB byte 0x11; pkt size=0x90, arit=0x02 -> rd_mem 1 cycle; wea 5 cycles after handshake, wr_data[31:0]=0x90203002, vec[15:0]=0x1190.
- Equal/in-range: stored 0x80/0x20, pkt size=0x50 -> size extremes unchanged at 0x80/0x20.
- Read timeout: rd_data_v never asserted -> o_rd_err pulses once after RD_TIMEOUT WAIT cycles, no wea, pkt_rdy=1 next cycle.
- Reset mid-WAIT: assert rst during WAIT -> outputs at reset values immediately, no wea after release, pkt_rdy=1 one cycle after release.
- Counter (macro defined): 3 completed updates plus 1 timeout -> o_upd_cnt=3; with macro undefined -> o_upd_cnt=0.
